rgb_frame_writer: RTL and testbench

RGB_FRAME_WRITER -- requirements
Module: rgb_frame_writer

---
 rtl/rgb_frame_writer_pkg.sv | 19 +
 rtl/rgb_frame_writer_word_fifo.sv | 54 +++++
 rtl/rgb_frame_writer.sv | 181 ++++++++++++++++++
 tb/tb_rgb_frame_writer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_frame_writer_pkg.sv
// Shared types for the RGB332 frame writer: FSM states and word-FIFO entries.
package rgb_frame_writer_pkg;

  localparam int unsigned WORD_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FLUSH,
    SWAP
  } state_e;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] addr;
    logic [31:0]            data;
    logic [3:0]             be;
  } fifo_entry_t;

endpackage

// File: rtl/rgb_frame_writer_word_fifo.sv
// Synchronous word FIFO; a push while full succeeds when a pop happens in the same cycle.
module word_fifo
  import rgb_frame_writer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  fifo_entry_t mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Status flags, accepted push/pop and next pointers.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/rgb_frame_writer.sv
// Packs RGB332 pixels into 32-bit words and writes them into a double-buffered
// frame store, swapping the displayed bank once a frame is fully committed.
module rgb_frame_writer
  import rgb_frame_writer_pkg::*;
#(
  parameter int unsigned PIXELS     = 160000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel_data,
  input  logic [17:0] pixel_address,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic        reader_busy,
  output logic        display_bank,
  output logic        frame_done,
  output logic        overflow
);

  state_e                 state_q, state_d;
  logic                   fv_q;
  logic                   write_bank_q, write_bank_d;
  logic                   display_bank_q, display_bank_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_done_q, frame_done_d;
  logic [31:0]            pk_data_q, pk_data_d;
  logic [3:0]             pk_be_q, pk_be_d;
  logic [WORD_ADDR_W-1:0] pk_idx_q, pk_idx_d;

  logic                   fv_rise, fv_fall, in_range;
  logic [1:0]             lane;
  logic [WORD_ADDR_W-1:0] idx;
  logic [31:0]            merged_data, fresh_data;
  logic [3:0]             merged_be, fresh_be;
  logic                   push, pop, fifo_full, fifo_empty;
  fifo_entry_t            push_entry, head;

  word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Memory write port driven straight from the FIFO head; zero while idle.
  always_comb begin
    mem_we       = !fifo_empty;
    pop          = mem_we && mem_ready;
    mem_addr     = mem_we ? {write_bank_q, head.addr} : '0;
    mem_wdata    = mem_we ? head.data : '0;
    mem_be       = mem_we ? head.be : '0;
    display_bank = display_bank_q;
    frame_done   = frame_done_q;
    overflow     = overflow_q;
  end

  // Frame FSM, pixel packer and push generation.
  always_comb begin
    state_d        = state_q;
    write_bank_d   = write_bank_q;
    display_bank_d = display_bank_q;
    overflow_d     = overflow_q;
    frame_done_d   = 1'b0;
    pk_data_d      = pk_data_q;
    pk_be_d        = pk_be_q;
    pk_idx_d       = pk_idx_q;
    push           = 1'b0;
    push_entry     = '0;

    fv_rise  = frame_valid && !fv_q;
    fv_fall  = !frame_valid && fv_q;
    in_range = 32'(pixel_address) < PIXELS;
    lane     = pixel_address[1:0];
    idx      = pixel_address[17:2];

    merged_data = pk_data_q;
    merged_data[{lane, 3'b000} +: 8] = pixel_data;
    merged_be   = pk_be_q | (4'b0001 << lane);
    fresh_data  = '0;
    fresh_data[{lane, 3'b000} +: 8] = pixel_data;
    fresh_be    = 4'b0001 << lane;

    unique case (state_q)
      IDLE: begin
        if (fv_rise) begin
          state_d      = CAPTURE;
          write_bank_d = !display_bank_q;
          overflow_d   = 1'b0;
          pk_data_d    = '0;
          pk_be_d      = '0;
          pk_idx_d     = '0;
        end
      end
      CAPTURE: begin
        if (fv_fall) begin
          push       = (pk_be_q != '0);
          push_entry = '{addr: pk_idx_q, data: pk_data_q, be: pk_be_q};
          pk_data_d  = '0;
          pk_be_d    = '0;
          state_d    = FLUSH;
        end else if (pixel_valid && in_range) begin
          if ((pk_be_q != '0) && (idx != pk_idx_q)) begin
            // Only one push per cycle: the held word goes out now; a new pixel
            // landing in lane 3 stays held until the next word change or frame end.
            push       = 1'b1;
            push_entry = '{addr: pk_idx_q, data: pk_data_q, be: pk_be_q};
            pk_data_d  = fresh_data;
            pk_be_d    = fresh_be;
            pk_idx_d   = idx;
          end else if (lane == 2'd3) begin
            push       = 1'b1;
            push_entry = '{addr: idx, data: merged_data, be: merged_be};
            pk_data_d  = '0;
            pk_be_d    = '0;
            pk_idx_d   = idx;
          end else begin
            pk_data_d = merged_data;
            pk_be_d   = merged_be;
            pk_idx_d  = idx;
          end
        end
      end
      FLUSH: begin
        if (fifo_empty) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        if (!reader_busy) begin
          frame_done_d = 1'b1;
          if (!overflow_q) begin
            display_bank_d = write_bank_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      // Held high so a frame already in progress at reset release is not captured.
      fv_q           <= 1'b1;
      write_bank_q   <= 1'b1;
      display_bank_q <= 1'b0;
      overflow_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      pk_data_q      <= '0;
      pk_be_q        <= '0;
      pk_idx_q       <= '0;
    end else begin
      state_q        <= state_d;
      fv_q           <= frame_valid;
      write_bank_q   <= write_bank_d;
      display_bank_q <= display_bank_d;
      overflow_q     <= overflow_d;
      frame_done_q   <= frame_done_d;
      pk_data_q      <= pk_data_d;
      pk_be_q        <= pk_be_d;
      pk_idx_q       <= pk_idx_d;
    end
  end

endmodule

// File: tb/tb_rgb_frame_writer.sv
// Directed bench for rgb_frame_writer: write log captured at the falling edge.
module tb_rgb_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_valid;
  logic        pixel_valid;
  logic [7:0]  pixel_data;
  logic [17:0] pixel_address;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_ready;
  logic        reader_busy;
  logic        display_bank;
  logic        frame_done;
  logic        overflow;

  int total = 0;
  int bad = 0;
  int fd_count = 0;

  logic [16:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [3:0]  log_be   [$];

  always #5 clk = ~clk;

  rgb_frame_writer #(.PIXELS(160000), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_valid   (frame_valid),
    .pixel_valid   (pixel_valid),
    .pixel_data    (pixel_data),
    .pixel_address (pixel_address),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_we        (mem_we),
    .mem_ready     (mem_ready),
    .reader_busy   (reader_busy),
    .display_bank  (display_bank),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  // Record accepted writes and frame_done cycles mid-cycle.
  always @(negedge clk) begin
    if (!reset && mem_we && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_be.push_back(mem_be);
    end
    if (frame_done) fd_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_be.delete();
    fd_count = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_valid = 1'b0;
    pixel_valid = 1'b0;
    pixel_data = '0;
    pixel_address = '0;
    mem_ready = 1'b1;
    reader_busy = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    clear_log();
  endtask

  task automatic send(input int first, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1'b1;
      pixel_address = 18'(first + i);
      pixel_data = base + 8'(i);
      tick();
    end
    pixel_valid = 1'b0;
  endtask

  task automatic frame_start();
    frame_valid = 1'b1;
    tick();
  endtask

  task automatic frame_end();
    frame_valid = 1'b0;
    tick();
  endtask

  task automatic wait_frame(input int budget);
    for (int c = 0; c < budget && fd_count == 0; c++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    frame_valid = 1'b0;
    pixel_valid = 1'b0;
    pixel_data = '0;
    pixel_address = '0;
    mem_ready = 1'b0;
    reader_busy = 1'b0;
    repeat (2) tick();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", mem_we); end
    total++; if (mem_be !== 4'h0) begin bad++; $display("FAIL reset_be got=%h want=0", mem_be); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
    total++; if (mem_addr !== 17'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
    total++; if (display_bank !== 1'b0) begin bad++; $display("FAIL reset_bank got=%b want=0", display_bank); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
  endtask

  task automatic test_basic();
    logic [16:0] ea [2] = '{17'h10000, 17'h10001};
    logic [31:0] ed [2] = '{32'h13121110, 32'h17161514};
    do_reset();
    frame_start();
    send(0, 4, 8'h10);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL basic_latency mem_we got=%b want=1", mem_we); end
    send(4, 4, 8'h14);
    frame_end();
    wait_frame(50);
    total++; if (fd_count != 1) begin bad++; $display("FAIL basic_done cycles got=%0d want=1", fd_count); end
    total++; if (log_addr.size() != 2) begin bad++; $display("FAIL basic_count got=%0d want=2", log_addr.size()); end
    for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
      total++;
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] || log_be[i] !== 4'hF) begin
        bad++;
        $display("FAIL basic_write%0d got=%h/%h/%h want=%h/%h/f", i, log_addr[i], log_data[i], log_be[i], ea[i], ed[i]);
      end
    end
    total++; if (display_bank !== 1'b1) begin bad++; $display("FAIL basic_bank got=%b want=1", display_bank); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] ea [2] = '{17'h00000, 17'h00001};
    logic [31:0] ed [2] = '{32'h33323130, 32'h37363534};
    clear_log();
    frame_start();
    send(0, 8, 8'h30);
    frame_end();
    wait_frame(50);
    total++; if (log_addr.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", log_addr.size()); end
    for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
      total++;
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] || log_be[i] !== 4'hF) begin
        bad++;
        $display("FAIL b2b_write%0d got=%h/%h/%h want=%h/%h/f", i, log_addr[i], log_data[i], log_be[i], ea[i], ed[i]);
      end
    end
    total++; if (display_bank !== 1'b0) begin bad++; $display("FAIL b2b_bank got=%b want=0", display_bank); end
  endtask

  task automatic test_partial();
    logic [16:0] ea [2] = '{17'h10000, 17'h10001};
    logic [31:0] ed [2] = '{32'hA3A2A1A0, 32'h000000A4};
    logic [3:0]  eb [2] = '{4'hF, 4'h1};
    do_reset();
    frame_start();
    send(0, 5, 8'hA0);
    frame_end();
    wait_frame(50);
    total++; if (log_addr.size() != 2) begin bad++; $display("FAIL partial_count got=%0d want=2", log_addr.size()); end
    for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
      total++;
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] || log_be[i] !== eb[i]) begin
        bad++;
        $display("FAIL partial_write%0d got=%h/%h/%h want=%h/%h/%h", i, log_addr[i], log_data[i], log_be[i], ea[i], ed[i], eb[i]);
      end
    end
    total++; if (display_bank !== 1'b1) begin bad++; $display("FAIL partial_bank got=%b want=1", display_bank); end
  endtask

  task automatic test_nonseq();
    do_reset();
    frame_start();
    send(2, 1, 8'h55);
    send(9, 1, 8'h66);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 17'h10000 || mem_be !== 4'h4 || mem_wdata !== 32'h00550000) begin
      bad++;
      $display("FAIL nonseq_first got=%b/%h/%h/%h want=1/10000/4/00550000", mem_we, mem_addr, mem_be, mem_wdata);
    end
    send(160000, 1, 8'h77);
    frame_end();
    wait_frame(50);
    total++; if (log_addr.size() != 2) begin bad++; $display("FAIL nonseq_count got=%0d want=2", log_addr.size()); end
    if (log_addr.size() >= 2) begin
      total++;
      if (log_addr[1] !== 17'h10002 || log_be[1] !== 4'h2 || log_data[1] !== 32'h00006600) begin
        bad++;
        $display("FAIL nonseq_last got=%h/%h/%h want=10002/2/00006600", log_addr[1], log_be[1], log_data[1]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] ed;
    do_reset();
    mem_ready = 1'b0;
    frame_start();
    send(0, 24, 8'h00);
    frame_end();
    repeat (3) tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    total++; if (fd_count != 0) begin bad++; $display("FAIL ovf_early_done got=%0d want=0", fd_count); end
    mem_ready = 1'b1;
    wait_frame(50);
    total++; if (fd_count != 1) begin bad++; $display("FAIL ovf_done got=%0d want=1", fd_count); end
    total++; if (log_addr.size() != 4) begin bad++; $display("FAIL ovf_count got=%0d want=4", log_addr.size()); end
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      ed = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      total++;
      if (log_addr[k] !== 17'h10000 + 17'(k) || log_data[k] !== ed) begin
        bad++;
        $display("FAIL ovf_write%0d got=%h/%h want=%h/%h", k, log_addr[k], log_data[k], 17'h10000 + 17'(k), ed);
      end
    end
    total++; if (display_bank !== 1'b0) begin bad++; $display("FAIL ovf_bank got=%b want=0", display_bank); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    clear_log();
    frame_start();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    send(0, 4, 8'hC0);
    frame_end();
    wait_frame(50);
    total++; if (display_bank !== 1'b1) begin bad++; $display("FAIL ovf_next_bank got=%b want=1", display_bank); end
  endtask

  task automatic test_reader_busy();
    do_reset();
    reader_busy = 1'b1;
    frame_start();
    send(0, 4, 8'hE0);
    frame_end();
    repeat (10) tick();
    total++; if (fd_count != 0 || frame_done !== 1'b0) begin bad++; $display("FAIL busy_hold done=%0d want=0", fd_count); end
    total++; if (display_bank !== 1'b0) begin bad++; $display("FAIL busy_hold_bank got=%b want=0", display_bank); end
    frame_valid = 1'b1;
    tick();
    reader_busy = 1'b0;
    tick();
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL busy_release_done got=%b want=1", frame_done); end
    total++; if (display_bank !== 1'b1) begin bad++; $display("FAIL busy_release_bank got=%b want=1", display_bank); end
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL busy_pulse_width got=%b want=0", frame_done); end
    send(0, 4, 8'hF0);
    frame_valid = 1'b0;
    repeat (10) tick();
    total++; if (log_addr.size() != 1) begin bad++; $display("FAIL skip_count got=%0d want=1", log_addr.size()); end
    if (log_addr.size() >= 1) begin
      total++;
      if (log_addr[0] !== 17'h10000 || log_data[0] !== 32'hE3E2E1E0) begin
        bad++;
        $display("FAIL busy_write got=%h/%h want=10000/e3e2e1e0", log_addr[0], log_data[0]);
      end
    end
    total++; if (fd_count != 1) begin bad++; $display("FAIL skip_done got=%0d want=1", fd_count); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed [2] = '{32'h23222120, 32'h27262524};
    do_reset();
    mem_ready = 1'b0;
    frame_start();
    send(0, 4, 8'h40);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL mid_pre_we got=%b want=1", mem_we); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0 || mem_be !== 4'h0) begin bad++; $display("FAIL mid_async got=%b/%h want=0/0", mem_we, mem_be); end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    clear_log();
    send(0, 4, 8'h99);
    frame_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (5) tick();
    total++; if (log_addr.size() != 0) begin bad++; $display("FAIL mid_discard got=%0d want=0", log_addr.size()); end
    frame_start();
    send(0, 8, 8'h20);
    frame_end();
    wait_frame(50);
    total++; if (log_addr.size() != 2) begin bad++; $display("FAIL mid_count got=%0d want=2", log_addr.size()); end
    for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
      total++;
      if (log_addr[i] !== 17'h10000 + 17'(i) || log_data[i] !== ed[i]) begin
        bad++;
        $display("FAIL mid_write%0d got=%h/%h want=%h/%h", i, log_addr[i], log_data[i], 17'h10000 + 17'(i), ed[i]);
      end
    end
    total++; if (display_bank !== 1'b1) begin bad++; $display("FAIL mid_bank got=%b want=1", display_bank); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_partial();
    test_nonseq();
    test_overflow();
    test_reader_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
